mmio_led_pwm: RTL
=================

// Module: mmio_led_pwm
// PURPOSE
//  Parametrised MMIO LED controller on the core data bus, next to the memory.
//  Snoops data-bus writes in its address window and drives NUM_CH LEDs.
//  Each channel has its own PWM brightness, with glitch-free duty updates at period
//  boundaries. Registers are readable with fixed 1-cycle latency.
// PARAMETERS
//  NUM_CH     6        LED channel count (1..16)
//  ADDR_W     16       data-bus address width
//  DATA_W     16       data-bus data width (>= DUTY_W, >= NUM_CH)
//  BASE_ADDR  16'hF000 first word address of register window
//  DUTY_W     8        PWM resolution in bits; period = 2**DUTY_W ticks
//  PRESCALE   64       clock cycles per PWM tick (>= 1)
//  ACTIVE_LOW 1        1: LED pin driven 0 when lit (Tang Primer LEDs)
// PORTS
//  clock       in   1       system clock
//  reset       in   1       async, active-low reset
//  mmio_addr   in   ADDR_W  data-bus address
//  mmio_wdata  in   DATA_W  data-bus write data
//  mmio_write  in   1       write strobe, 1 cycle per access
//  mmio_read   in   1       read strobe, 1 cycle per access
//  mmio_rdata  out  DATA_W  read data, valid when mmio_rvalid=1
//  mmio_rvalid out  1       1-cycle pulse, one clock after an in-window read
//  led         out  NUM_CH  LED pins, registered
// BEHAVIOUR
//  - Window: off = mmio_addr - BASE_ADDR. Hit when off < 2+NUM_CH. Out-of-window accesses are ignored, with no rvalid.
//  - Map: 0 CTRL [0]=EN, [1]=RESTART (write-1 pulse, reads 0). 1 BLINK (see CONFIGURATION).
//    2+i DUTY[i] [DUTY_W-1:0]. Unused bits read 0 and writes to them are ignored.
//  - Write in cycle N: register readable in cycle N+1. A DUTY write goes to the shadow copy only.
//  - Timebase: presc counts 0..PRESCALE-1. On wrap: tick. Each tick increments cnt (DUTY_W bits). cnt wraps to 0.
//  - Period start = tick with cnt==all-ones. At period start: active_duty[i] <= shadow_duty[i] for all i.
//  - lit[i] = EN && (active_duty[i]==all-ones || cnt < active_duty[i]).
//    Duty 0 = always off. Duty all-ones = always on, with no 1-tick gap.
//  - led[i] <= lit[i] ^ ACTIVE_LOW. One cycle of latency from cnt to pin.
//  - RESTART: presc and cnt go to 0 next cycle. Shadow duties are copied to active in the same cycle.
//  - EN=0: all LEDs off. The timebase keeps running.
//  - Read and write in the same cycle: the write takes effect, and rdata returns the old value.
//  - Reset (any time, async): CTRL=0, all duties 0, presc=cnt=0, rdata=0, rvalid=0, led={NUM_CH{ACTIVE_LOW}} (all off).
// CONFIGURATION
//  MMIO_LED_BLINK_EN defined:
//    - BLINK reg [NUM_CH-1:0] is a per-channel mask.
//    - blink_ph toggles every 2**7 PWM periods.
//    - A masked channel is forced off while blink_ph=1. blink_ph resets to 0 and is cleared by RESTART.
//  MMIO_LED_BLINK_EN undefined:
//    - Offset 1 still decodes: reads 0, writes are ignored, rvalid is still issued.
//    - No blink logic is instantiated.
// STRUCTURE
//  - Package mmio_led_pkg: offsets CTRL_OFF=0, BLINK_OFF=1, DUTY_OFF=2; CTRL bit indices; blink-phase width 7.
//  - Sub-module mmio_led_timebase (PRESCALE, DUTY_W): outputs tick, cnt, period_start; input restart.
//  - Top level holds register file, decode, compare and output regs.
// TESTING
//  - Reset: hold reset=0 -> led=6'h3F, rvalid=0. Release, read CTRL -> rdata=0, one rvalid pulse.
//  - Duty: PRESCALE=1, write CTRL=1, DUTY[0]=64 -> after next period start, led[0] lit 64 of every 256 cycles, other LEDs off.
//  - Extremes: DUTY[1]=0 -> never lit. DUTY[2]=255 -> continuously lit with no gap over 3 periods.
//  - Shadow: change DUTY[0] 64->200 mid-period -> current period keeps 64, next period has 200.
//    Immediate read returns 200.
//  - Window and RESTART: write to BASE_ADDR+8 and BASE_ADDR-1 -> no state change, no rvalid.
//    Write CTRL=3 -> cnt=0 next cycle, CTRL reads 1.
//  - Blink (macro on): BLINK=1, DUTY[0]=255 -> led[0] alternates lit and off every 128 periods.
//    With macro off: BLINK reads 0.

Source files
------------

// File: rtl/mmio_led_pkg.sv
// Shared register map, CTRL bit positions and blink-phase width for the MMIO LED PWM block.
package mmio_led_pkg;

   localparam int unsigned CTRL_OFF  = 0;
   localparam int unsigned BLINK_OFF = 1;
   localparam int unsigned DUTY_OFF  = 2;

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_RESTART_BIT = 1;

   // Blink phase flips once this many bits of PWM periods have rolled over.
   localparam int unsigned BLINK_PH_W = 7;

endpackage

// File: rtl/mmio_led_timebase.sv
// PWM timebase: prescaler producing ticks, a DUTY_W-bit tick counter and a period-start strobe.
module mmio_led_timebase #(
   parameter int unsigned PRESCALE = 64,
   parameter int unsigned DUTY_W   = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              restart,
   output logic              tick,
   output logic [DUTY_W-1:0] cnt,
   output logic              period_start
);

   localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [DUTY_W-1:0]  cnt_q, cnt_d;

   assign tick         = (presc_q == PRESC_W'(PRESCALE - 1));
   assign period_start = tick && (&cnt_q);
   assign cnt          = cnt_q;

   always_comb begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      cnt_d   = tick ? cnt_q + DUTY_W'(1) : cnt_q;
      if (restart) begin
         presc_d = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/mmio_led_pwm.sv
// MMIO LED controller: snoops bus writes in its window, per-channel PWM with shadowed duties.
// Optional per-channel blink mask is compiled in when MMIO_LED_BLINK_EN is defined.
module mmio_led_pwm
   import mmio_led_pkg::*;
#(
   parameter int unsigned       NUM_CH     = 6,
   parameter int unsigned       ADDR_W     = 16,
   parameter int unsigned       DATA_W     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(16'hF000),
   parameter int unsigned       DUTY_W     = 8,
   parameter int unsigned       PRESCALE   = 64,
   parameter bit                ACTIVE_LOW = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mmio_addr,
   input  logic [DATA_W-1:0] mmio_wdata,
   input  logic              mmio_write,
   input  logic              mmio_read,
   output logic [DATA_W-1:0] mmio_rdata,
   output logic              mmio_rvalid,
   output logic [NUM_CH-1:0] led
);

   logic [ADDR_W-1:0] off;
   logic              hit, wr_hit, rd_hit, restart;
   logic              tick, period_start;
   logic [DUTY_W-1:0] cnt;

   logic              en_q, en_d;
   logic [DUTY_W-1:0] shadow_q [NUM_CH];
   logic [DUTY_W-1:0] shadow_d [NUM_CH];
   logic [DUTY_W-1:0] active_q [NUM_CH];
   logic [DUTY_W-1:0] active_d [NUM_CH];
   logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
   logic              rvalid_q;
   logic [NUM_CH-1:0] led_q, led_d, lit, blink_off;

   // Wrapping subtraction makes addresses below BASE_ADDR land far outside the window.
   assign off     = mmio_addr - BASE_ADDR;
   assign hit     = (off < ADDR_W'(DUTY_OFF + NUM_CH));
   assign wr_hit  = mmio_write && hit;
   assign rd_hit  = mmio_read && hit;
   assign restart = wr_hit && (off == ADDR_W'(CTRL_OFF)) && mmio_wdata[CTRL_RESTART_BIT];

   mmio_led_timebase #(
      .PRESCALE(PRESCALE),
      .DUTY_W  (DUTY_W)
   ) u_timebase (
      .clock       (clock),
      .reset       (reset),
      .restart     (restart),
      .tick        (tick),
      .cnt         (cnt),
      .period_start(period_start)
   );

`ifdef MMIO_LED_BLINK_EN
   logic [NUM_CH-1:0]     blink_q, blink_d;
   logic [BLINK_PH_W-1:0] bper_q, bper_d;
   logic                  blink_ph_q, blink_ph_d;

   always_comb begin
      blink_d    = blink_q;
      bper_d     = bper_q;
      blink_ph_d = blink_ph_q;
      if (wr_hit && (off == ADDR_W'(BLINK_OFF))) blink_d = mmio_wdata[NUM_CH-1:0];
      if (restart) begin
         bper_d     = '0;
         blink_ph_d = 1'b0;
      end else if (period_start) begin
         bper_d = bper_q + BLINK_PH_W'(1);
         if (&bper_q) blink_ph_d = ~blink_ph_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blink_q    <= '0;
         bper_q     <= '0;
         blink_ph_q <= 1'b0;
      end else begin
         blink_q    <= blink_d;
         bper_q     <= bper_d;
         blink_ph_q <= blink_ph_d;
      end
   end

   assign blink_off = blink_q & {NUM_CH{blink_ph_q}};
`else
   assign blink_off = '0;
`endif

   always_comb begin
      en_d     = en_q;
      shadow_d = shadow_q;
      active_d = active_q;
      // Duties only move to the comparator on a period boundary or a restart, so pulses never tear.
      if (restart || period_start) active_d = shadow_q;
      if (wr_hit) begin
         if (off == ADDR_W'(CTRL_OFF)) en_d = mmio_wdata[CTRL_EN_BIT];
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (off == ADDR_W'(DUTY_OFF + i)) shadow_d[i] = mmio_wdata[DUTY_W-1:0];
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (off == ADDR_W'(CTRL_OFF)) rd_val[CTRL_EN_BIT] = en_q;
`ifdef MMIO_LED_BLINK_EN
      if (off == ADDR_W'(BLINK_OFF)) rd_val[NUM_CH-1:0] = blink_q;
`endif
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (off == ADDR_W'(DUTY_OFF + i)) rd_val[DUTY_W-1:0] = shadow_q[i];
      end
      rdata_d = rd_hit ? rd_val : rdata_q;
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         lit[i] = en_q && ((&active_q[i]) || (cnt < active_q[i])) && !blink_off[i];
      end
      led_d = lit ^ {NUM_CH{ACTIVE_LOW}};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         en_q     <= 1'b0;
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         led_q    <= {NUM_CH{ACTIVE_LOW}};
      end else begin
         en_q     <= en_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rd_hit;
         led_q    <= led_d;
      end
   end

   assign mmio_rdata  = rdata_q;
   assign mmio_rvalid = rvalid_q;
   assign led         = led_q;

   logic unused_ok;
   assign unused_ok = ^{tick, mmio_wdata};

endmodule
